bip_control: RTL and testbench

Control unit for the BIP accumulator processor: fetches 16-bit instructions from program memory, decodes them and drives the accumulator datapath select, write and ALU-operation controls plus data-memory strobes. Each instruction takes a two-cycle FETCH/EXEC sequence. The unit stops permanently on HLT until reset. It sits between program memory, data memory and the datapath.

---
 rtl/bip_pkg.sv | 28 ++
 rtl/bip_decoder.sv | 61 ++++++
 rtl/bip_control.sv | 128 ++++++++++++
 tb/tb_bip_control.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: word widths, opcodes,
// FSM state encoding and accumulator source select codes.
package bip_pkg;

    localparam int NB_BITS = 16;
    localparam int NB_ADDR = 11;
    localparam int NB_OPC  = 5;

    localparam logic [NB_OPC-1:0] OPC_HLT  = 5'b00000;
    localparam logic [NB_OPC-1:0] OPC_STO  = 5'b00001;
    localparam logic [NB_OPC-1:0] OPC_LD   = 5'b00010;
    localparam logic [NB_OPC-1:0] OPC_LDI  = 5'b00011;
    localparam logic [NB_OPC-1:0] OPC_ADD  = 5'b00100;
    localparam logic [NB_OPC-1:0] OPC_ADDI = 5'b00101;
    localparam logic [NB_OPC-1:0] OPC_SUB  = 5'b00110;
    localparam logic [NB_OPC-1:0] OPC_SUBI = 5'b00111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_A_MEM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: maps an opcode to the datapath/memory
// control bundle. Unknown opcodes decode to an all-zero (NOP) bundle.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [NB_OPC-1:0] opc_i,
    output logic [1:0]        sel_a_o,
    output logic              sel_b_o,
    output logic              op_code_o,
    output logic              wr_acc_o,
    output logic              wr_ram_o,
    output logic              rd_ram_o
);

    always_comb begin
        sel_a_o   = SEL_A_MEM;
        sel_b_o   = 1'b0;
        op_code_o = 1'b0;
        wr_acc_o  = 1'b0;
        wr_ram_o  = 1'b0;
        rd_ram_o  = 1'b0;
        case (opc_i)
            OPC_STO: begin
                wr_ram_o = 1'b1;
            end
            OPC_LD: begin
                sel_a_o  = SEL_A_MEM;
                rd_ram_o = 1'b1;
                wr_acc_o = 1'b1;
            end
            OPC_LDI: begin
                sel_a_o  = SEL_A_IMM;
                wr_acc_o = 1'b1;
            end
            OPC_ADD: begin
                sel_a_o   = SEL_A_ALU;
                op_code_o = 1'b1;
                rd_ram_o  = 1'b1;
                wr_acc_o  = 1'b1;
            end
            OPC_ADDI: begin
                sel_a_o   = SEL_A_ALU;
                sel_b_o   = 1'b1;
                op_code_o = 1'b1;
                wr_acc_o  = 1'b1;
            end
            OPC_SUB: begin
                sel_a_o  = SEL_A_ALU;
                rd_ram_o = 1'b1;
                wr_acc_o = 1'b1;
            end
            OPC_SUBI: begin
                sel_a_o  = SEL_A_ALU;
                sel_b_o  = 1'b1;
                wr_acc_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: FETCH/EXEC/HALT sequencer, program counter and
// instruction register. Define BIP_CYCLE_COUNTER_EN to add the o_cycles counter.
module bip_control
    import bip_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic [NB_BITS-1:0] i_instr,
    output logic [NB_ADDR-1:0] o_addr_pc,
    output logic [NB_ADDR-1:0] o_addr_data,
    output logic [NB_ADDR-1:0] o_data_ins,
    output logic [1:0]         o_sel_a,
    output logic               o_sel_b,
    output logic               o_wr_acc,
    output logic               o_op_code,
    output logic               o_wr_ram,
    output logic               o_rd_ram,
`ifdef BIP_CYCLE_COUNTER_EN
    output logic [31:0]        o_cycles,
`endif
    output logic               o_halt
);

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] pc_q, pc_d;
    logic [NB_BITS-1:0] ir_q, ir_d;

    logic [NB_OPC-1:0]  opcode;
    logic               is_hlt;
    logic               exec_active;

    logic [1:0]         dec_sel_a;
    logic               dec_sel_b;
    logic               dec_op_code;
    logic               dec_wr_acc;
    logic               dec_wr_ram;
    logic               dec_rd_ram;

    assign opcode = ir_q[NB_BITS-1 -: NB_OPC];
    assign is_hlt = (opcode == OPC_HLT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (i_enable) begin
            case (state_q)
                ST_FETCH: begin
                    ir_d    = i_instr;
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_hlt) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    bip_decoder u_decoder (
        .opc_i     (opcode),
        .sel_a_o   (dec_sel_a),
        .sel_b_o   (dec_sel_b),
        .op_code_o (dec_op_code),
        .wr_acc_o  (dec_wr_acc),
        .wr_ram_o  (dec_wr_ram),
        .rd_ram_o  (dec_rd_ram)
    );

    // A stalled or resetting EXEC must not leak strobes into the datapath.
    assign exec_active = (state_q == ST_EXEC) && i_enable && !i_rst;

    assign o_addr_pc   = pc_q;
    assign o_addr_data = ir_q[NB_ADDR-1:0];
    assign o_data_ins  = ir_q[NB_ADDR-1:0];
    assign o_sel_a     = exec_active ? dec_sel_a : SEL_A_MEM;
    assign o_sel_b     = exec_active & dec_sel_b;
    assign o_op_code   = exec_active & dec_op_code;
    assign o_wr_acc    = exec_active & dec_wr_acc;
    assign o_wr_ram    = exec_active & dec_wr_ram;
    assign o_rd_ram    = exec_active & dec_rd_ram;
    assign o_halt      = (state_q == ST_HALT);

`ifdef BIP_CYCLE_COUNTER_EN
    logic [31:0] cycles_q, cycles_d;
    logic        count_en;

    // The EXEC of HLT is not counted, so the frozen value is the cycles spent running.
    assign count_en = i_enable && (state_q != ST_HALT) && !((state_q == ST_EXEC) && is_hlt);

    always_comb begin
        cycles_d = cycles_q;
        if (count_en && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign o_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: a program memory with combinational
// read feeds i_instr, and an instruction-level reference model predicts outputs.
module tb_bip_control;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_enable = 1'b0;
    logic [15:0] i_instr;
    logic [10:0] o_addr_pc, o_addr_data, o_data_ins;
    logic [1:0]  o_sel_a;
    logic        o_sel_b, o_wr_acc, o_op_code, o_wr_ram, o_rd_ram, o_halt;
`ifdef BIP_CYCLE_COUNTER_EN
    logic [31:0] o_cycles;
`endif

    logic [15:0] mem [0:2047];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: where the processor is in its instruction sequence.
    bit          m_valid = 1'b0;
    bit          m_halted;
    bit          m_in_exec;
    int unsigned m_pc;
    logic [15:0] m_ir;
    longint      m_cycles;

    always #5 i_clk = ~i_clk;

    assign i_instr = mem[o_addr_pc];

    bip_control dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_enable    (i_enable),
        .i_instr     (i_instr),
        .o_addr_pc   (o_addr_pc),
        .o_addr_data (o_addr_data),
        .o_data_ins  (o_data_ins),
        .o_sel_a     (o_sel_a),
        .o_sel_b     (o_sel_b),
        .o_wr_acc    (o_wr_acc),
        .o_op_code   (o_op_code),
        .o_wr_ram    (o_wr_ram),
        .o_rd_ram    (o_rd_ram),
`ifdef BIP_CYCLE_COUNTER_EN
        .o_cycles    (o_cycles),
`endif
        .o_halt      (o_halt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction table: {sel_a, sel_b, op_code, wr_acc, wr_ram, rd_ram}.
    function automatic logic [6:0] strobes_for(input logic [4:0] opc);
        case (opc)
            5'd1:    return 7'b00_0_0_0_1_0;
            5'd2:    return 7'b00_0_0_1_0_1;
            5'd3:    return 7'b01_0_0_1_0_0;
            5'd4:    return 7'b10_0_1_1_0_1;
            5'd5:    return 7'b10_1_1_1_0_0;
            5'd6:    return 7'b10_0_0_1_0_1;
            5'd7:    return 7'b10_1_0_1_0_0;
            default: return 7'b0;
        endcase
    endfunction

    task automatic step(input bit en, input bit rst);
        logic [6:0] exp_s;
        i_enable = en;
        i_rst    = rst;
        #1;
        if (m_valid) begin
            exp_s = (m_in_exec && en && !rst) ? strobes_for(m_ir[15:11]) : 7'b0;
            check_val("pc", 32'(o_addr_pc), m_pc);
            check_val("addr_data", 32'(o_addr_data), 32'(m_ir[10:0]));
            check_val("data_ins", 32'(o_data_ins), 32'(m_ir[10:0]));
            check_val("strobes", 32'({o_sel_a, o_sel_b, o_op_code, o_wr_acc, o_wr_ram, o_rd_ram}),
                      32'(exp_s));
            check_val("halt", 32'(o_halt), 32'(m_halted));
`ifdef BIP_CYCLE_COUNTER_EN
            check_val("cycles", o_cycles, 32'(m_cycles));
`endif
        end
        @(posedge i_clk);
        if (rst) begin
            m_valid   = 1'b1;
            m_halted  = 1'b0;
            m_in_exec = 1'b0;
            m_pc      = 0;
            m_ir      = '0;
            m_cycles  = 0;
        end else if (en && m_valid && !m_halted) begin
            if (!m_in_exec) begin
                m_ir      = mem[m_pc];
                m_in_exec = 1'b1;
                m_cycles++;
            end else if (m_ir[15:11] == 5'd0) begin
                m_halted  = 1'b1;
                m_in_exec = 1'b0;
            end else begin
                m_pc      = (m_pc + 1) % 2048;
                m_in_exec = 1'b0;
                m_cycles++;
            end
        end
        @(negedge i_clk);
    endtask

    task automatic clear_mem(input logic [15:0] fill);
        for (int a = 0; a < 2048; a++) mem[a] = fill;
    endtask

    task automatic run(input string name, input int n);
        step(1'b1, 1'b1);
        for (int c = 0; c < n; c++) step(1'b1, 1'b0);
        $display("program %s: %0d cycles, %0d checks so far", name, n, n_vec);
    endtask

    initial begin
        clear_mem(16'h0000);
        step(1'b1, 1'b1);

        // LDI 5, ADDI 3, HLT, then linger in HALT and reset out of it
        clear_mem(16'h0000);
        mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0000;
        run("ldi_addi_hlt", 12);
        check_val("halt_pc", 32'(o_addr_pc), 32'd2);
        step(1'b1, 1'b1);
        check_val("halt_after_rst", 32'(o_halt), 32'd0);
        check_val("pc_after_rst", 32'(o_addr_pc), 32'd0);

        // LD / SUB / STO
        clear_mem(16'h0000);
        mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'h0812;
        run("ld_sub_sto", 10);

        // Unknown opcode behaves as NOP
        clear_mem(16'h0000);
        mem[0] = 16'hF800; mem[1] = 16'h1807;
        run("nop_opcode", 8);

        // Stall in the middle of an ADDI
        clear_mem(16'h0000);
        mem[0] = 16'h2803;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0);
        check_val("stall_pc", 32'(o_addr_pc), 32'd1);
        $display("program stall_addi: %0d checks so far", n_vec);

`ifdef BIP_CYCLE_COUNTER_EN
        clear_mem(16'h0000);
        mem[0] = 16'h1801;
        run("cycle_count", 8);
        check_val("cycles_frozen", o_cycles, 32'd3);
`endif

        // Straight-line NOPs through the PC wrap
        clear_mem(16'hF800);
        run("nop_wrap", 2 * 2048 + 8);

        // Random programs, enables and resets
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 2048; a++) begin
                int k;
                logic [4:0] op;
                k  = $urandom_range(0, 99);
                op = (k < 2) ? 5'd0 : (k < 90) ? 5'($urandom_range(1, 7)) : 5'($urandom_range(8, 31));
                mem[a] = {op, 11'($urandom)};
            end
            step(1'b1, 1'b1);
            for (int c = 0; c < 600; c++)
                step($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0);
            $display("program random_%0d: 600 cycles, %0d checks so far", r, n_vec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
